// File: rtl/clf_stream_pkg.sv
// Shared types and width helpers for the printed-MLP stream wrapper.
package clf_stream_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } clf_state_t;

    // Index widths stay at least one bit so a single-feature build still elaborates.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned scnt_width(input int unsigned s);
        return $clog2(s) + 1;
    endfunction

    localparam int unsigned NUM_A_DEF         = 11;
    localparam int unsigned SETTLE_CYCLES_DEF = 4;
    localparam int unsigned IDX_W             = idx_width(NUM_A_DEF);
    localparam int unsigned SCNT_W            = scnt_width(SETTLE_CYCLES_DEF);

endpackage

// File: rtl/feature_slot_reg.sv
// Feature slot array: one register per feature, indexed write and an optional
// zero-fill of every slot above the written index in the same cycle.
module feature_slot_reg
    import clf_stream_pkg::*;
#(
    parameter int unsigned NUM_A   = 11,
    parameter int unsigned WIDTH_A = 4,
    parameter int unsigned IDX_BITS = idx_width(NUM_A)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [IDX_BITS-1:0]        wr_idx,
    input  logic [WIDTH_A-1:0]         wr_data,
    input  logic                       zero_fill,
    output logic [NUM_A*WIDTH_A-1:0]   slots
);

    generate
        for (genvar gi = 0; gi < NUM_A; gi++) begin : g_slot
            logic [WIDTH_A-1:0] slot_q;
            logic [WIDTH_A-1:0] slot_d;

            always_comb begin
                slot_d = slot_q;
                if (wr_en && (wr_idx == IDX_BITS'(gi))) begin
                    slot_d = wr_data;
                end else if (wr_en && zero_fill && (IDX_BITS'(gi) > wr_idx)) begin
                    slot_d = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign slots[(gi+1)*WIDTH_A-1 : gi*WIDTH_A] = slot_q;
        end
    endgenerate

endmodule

// File: rtl/clf_stream_wrapper.sv
// Serial-feature front end for the combinational classifier: load, hold the
// packed inputs for a settle window, then present the captured result.
module clf_stream_wrapper
    import clf_stream_pkg::*;
#(
    parameter int unsigned WIDTH_A       = 4,
    parameter int unsigned NUM_A         = 11,
    parameter int unsigned OUTWIDTH      = 21,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       feat_valid,
    output logic                       feat_ready,
    input  logic [WIDTH_A-1:0]         feat_data,
    input  logic                       feat_last,
    output logic [NUM_A*WIDTH_A-1:0]   clf_inp,
    input  logic [OUTWIDTH-1:0]        clf_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OUTWIDTH-1:0]        res_data,
    output logic                       res_err,
    output logic [CNT_W-1:0]           sample_cnt
);

    localparam int unsigned IDX_BITS  = idx_width(NUM_A);
    localparam int unsigned SCNT_BITS = scnt_width(SETTLE_CYCLES);

    clf_state_t            state_q, state_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [SCNT_BITS-1:0]  scnt_q, scnt_d;
    logic                  err_q, err_d;
    logic                  feat_ready_q, feat_ready_d;
    logic                  res_valid_q, res_valid_d;
    logic [OUTWIDTH-1:0]   res_data_q, res_data_d;
    logic                  res_err_q, res_err_d;
    logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;

    logic                  wr_en;
    logic                  zero_fill;
    logic                  last_slot;

    assign last_slot = (idx_q == IDX_BITS'(NUM_A - 1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        scnt_d       = scnt_q;
        err_d        = err_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
        sample_cnt_d = sample_cnt_q;
        wr_en        = 1'b0;
        zero_fill    = 1'b0;

        case (state_q)
            LOAD: begin
                if (feat_valid && feat_ready_q) begin
                    wr_en = 1'b1;
                    if (last_slot || feat_last) begin
                        state_d = SETTLE;
                        scnt_d  = SCNT_BITS'(SETTLE_CYCLES - 1);
                        // Short frame blanks the unused tail; long frame just flags it.
                        if (!last_slot) begin
                            zero_fill = 1'b1;
                            err_d     = 1'b1;
                        end else if (!feat_last) begin
                            err_d     = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (scnt_q == '0) begin
                    res_data_d  = clf_out;
                    res_err_d   = err_q;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    scnt_d = scnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d  = 1'b0;
                    sample_cnt_d = sample_cnt_q + 1'b1;
                    idx_d        = '0;
                    err_d        = 1'b0;
                    scnt_d       = SCNT_BITS'(SETTLE_CYCLES - 1);
                    state_d      = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        feat_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            idx_q        <= '0;
            scnt_q       <= SCNT_BITS'(SETTLE_CYCLES - 1);
            err_q        <= 1'b0;
            feat_ready_q <= 1'b1;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            scnt_q       <= scnt_d;
            err_q        <= err_d;
            feat_ready_q <= feat_ready_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    feature_slot_reg #(
        .NUM_A    (NUM_A),
        .WIDTH_A  (WIDTH_A),
        .IDX_BITS (IDX_BITS)
    ) u_slots (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_idx    (idx_q),
        .wr_data   (feat_data),
        .zero_fill (zero_fill),
        .slots     (clf_inp)
    );

    assign feat_ready = feat_ready_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_clf_stream_wrapper.sv
// Directed bench for clf_stream_wrapper; the classifier is modelled as the
// zero-extended sum of all feature slots.
module tb_clf_stream_wrapper;

    localparam int WIDTH_A  = 4;
    localparam int NUM_A    = 11;
    localparam int OUTWIDTH = 21;
    localparam int SETTLE   = 3;
    localparam int CNT_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      feat_valid;
    logic                      feat_ready;
    logic [WIDTH_A-1:0]        feat_data;
    logic                      feat_last;
    logic [NUM_A*WIDTH_A-1:0]  clf_inp;
    logic [OUTWIDTH-1:0]       clf_out;
    logic                      res_valid;
    logic                      res_ready;
    logic [OUTWIDTH-1:0]       res_data;
    logic                      res_err;
    logic [CNT_W-1:0]          sample_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    logic [WIDTH_A-1:0] feat_vals [0:NUM_A-1];

    always #5 clk = ~clk;

    always_comb begin
        clf_out = '0;
        for (int i = 0; i < NUM_A; i++) begin
            clf_out = clf_out + OUTWIDTH'(clf_inp[i*WIDTH_A +: WIDTH_A]);
        end
    end

    clf_stream_wrapper #(
        .WIDTH_A       (WIDTH_A),
        .NUM_A         (NUM_A),
        .OUTWIDTH      (OUTWIDTH),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .feat_data  (feat_data),
        .feat_last  (feat_last),
        .clf_inp    (clf_inp),
        .clf_out    (clf_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .sample_cnt (sample_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [WIDTH_A-1:0] d, input bit last);
        int w = 0;
        feat_valid = 1'b1;
        feat_data  = d;
        feat_last  = last;
        while (!feat_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) check("beat_timeout", 64'd0, 64'd1);
        tick();
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    task automatic do_sample(input string tag, input int n, input int last_at,
                             input int exp_sum, input bit exp_err, input int hold_cycles,
                             input bit ready_early, input bit junk_after, input bit gaps);
        int cycles = 0;
        res_ready = ready_early;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_beat(feat_vals[i], i == last_at);
        end
        if (junk_after) begin
            feat_valid = 1'b1;
            feat_data  = 4'hF;
            check({tag, "_extra_beat_ready"}, 64'(feat_ready), 64'd0);
        end
        while (!res_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        feat_valid = 1'b0;
        check({tag, "_latency"}, 64'(cycles), 64'(SETTLE));
        check({tag, "_data"}, 64'(res_data), 64'(exp_sum));
        check({tag, "_err"}, 64'(res_err), 64'(exp_err));
        check({tag, "_cnt_before"}, 64'(sample_cnt), 64'(exp_cnt));
        for (int k = 0; k < hold_cycles; k++) begin
            tick();
            check({tag, "_bp_valid"}, 64'(res_valid), 64'd1);
            check({tag, "_bp_data"}, 64'(res_data), 64'(exp_sum));
            check({tag, "_bp_fready"}, 64'(feat_ready), 64'd0);
            check({tag, "_bp_cnt"}, 64'(sample_cnt), 64'(exp_cnt));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        check({tag, "_cnt_after"}, 64'(sample_cnt), 64'(exp_cnt));
        check({tag, "_valid_after"}, 64'(res_valid), 64'd0);
        check({tag, "_fready_after"}, 64'(feat_ready), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_feat_ready"}, 64'(feat_ready), 64'd1);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_res_data"}, 64'(res_data), 64'd0);
        check({tag, "_res_err"}, 64'(res_err), 64'd0);
        check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
        check({tag, "_clf_inp"}, 64'(clf_inp), 64'd0);
    endtask

    initial begin
        int sum;
        bit pulsed;
        rst_n      = 1'b0;
        feat_valid = 1'b0;
        feat_data  = '0;
        feat_last  = 1'b0;
        res_ready  = 1'b0;
        repeat (2) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        // 1: features 1..11, sum 66, consumer already ready
        for (int i = 0; i < NUM_A; i++) feat_vals[i] = WIDTH_A'(i + 1);
        do_sample("normal", NUM_A, NUM_A - 1, 66, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        // 2: all-15 sample, then a short 3-beat frame
        for (int i = 0; i < NUM_A; i++) feat_vals[i] = 4'hF;
        do_sample("all15", NUM_A, NUM_A - 1, 165, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NUM_A; i++) feat_vals[i] = 4'h5;
        do_sample("early", 3, 2, 15, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        check("early_low_slots", 64'(clf_inp[11:0]), 64'h555);
        check("early_zero_tail", 64'(clf_inp[NUM_A*WIDTH_A-1:12]), 64'd0);

        // 3: eleven 2s without feat_last; a 12th beat is offered and refused
        for (int i = 0; i < NUM_A; i++) feat_vals[i] = 4'h2;
        do_sample("missing", NUM_A, -1, 22, 1'b1, 0, 1'b0, 1'b1, 1'b0);

        // 4: result backpressure for 10 cycles
        for (int i = 0; i < NUM_A; i++) feat_vals[i] = WIDTH_A'(11 - i);
        do_sample("bp", NUM_A, NUM_A - 1, 66, 1'b0, 10, 1'b0, 1'b0, 1'b0);

        // 5: asynchronous reset during SETTLE
        for (int i = 0; i < NUM_A; i++) send_beat(4'h7, i == NUM_A - 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        pulsed = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (res_valid) pulsed = 1'b1;
        end
        check("midreset_no_result", 64'(pulsed), 64'd0);

        // 6: five gapped samples, counter wraps 1,2,3,0,1
        for (int s = 0; s < 5; s++) begin
            sum = 0;
            for (int i = 0; i < NUM_A; i++) begin
                feat_vals[i] = WIDTH_A'((i * 7 + s * 3) % 16);
                sum += (i * 7 + s * 3) % 16;
            end
            do_sample($sformatf("wrap%0d", s), NUM_A, NUM_A - 1, sum, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clf_stream_wrapper.md
# clf_stream_wrapper

Sequential front-end for the combinational printed-MLP classifier `top`. It accepts features serially over a valid/ready stream and assembles them into the packed `inp` vector. It holds that vector stable for a programmable settle time, which is needed because printed logic is slow. It then captures the classifier's `out` and presents it on a result valid/ready stream. It replaces the file-driven bench harness and generalises feature width, feature count, output width and settle time.

## Interface
- `WIDTH_A`, 4, bits per feature.
- `NUM_A`, 11, features per sample (≥1).
- `OUTWIDTH`, 21, classifier output width.
- `SETTLE_CYCLES`, 4, cycles `clf_inp` is held before capture (≥1).
- `CNT_W`, 16, width of the sample counter.

Ports:
- `clk` input, 1 bit, single clock; all logic is on the rising edge.
- `rst_n` input, 1 bit, asynchronous active-low reset.
- `feat_valid` input, 1 bit, feature beat valid.
- `feat_ready` output, 1 bit, wrapper accepts a feature beat.
- `feat_data` input, `WIDTH_A` bits, unsigned feature value.
- `feat_last` input, 1 bit, marks the final feature of a sample.
- `clf_inp` output, `NUM_A*WIDTH_A` bits, packed features to `top.inp`; slot i occupies bits [(i+1)*WIDTH_A-1 : i*WIDTH_A].
- `clf_out` input, `OUTWIDTH` bits, from `top.out`.
- `res_valid` output, 1 bit, result available.
- `res_ready` input, 1 bit, consumer accepts the result.
- `res_data` output, `OUTWIDTH` bits, captured classifier output.
- `res_err` output, 1 bit, framing error for this sample.
- `sample_cnt` output, `CNT_W` bits, number of results accepted; wraps modulo 2^CNT_W.

## Operation
- The FSM has three states: LOAD, SETTLE, HOLD. Reset enters LOAD.
- **LOAD:**
  - `feat_ready`=1.
  - Each handshake (`feat_valid & feat_ready`) writes `feat_data` into slot `idx`, then increments `idx`.
  - The transition to SETTLE occurs on the handshake where `idx==NUM_A-1` or `feat_last`=1, whichever comes first.
- **Early `feat_last`** (handshake at `idx<NUM_A-1`):
  - Slots idx+1..NUM_A-1 are written to zero in the same cycle.
  - `err_q` is set.
- **Missing `feat_last`** on the NUM_A-th beat: `err_q` is set. The beat is still accepted and the sample proceeds.
- **SETTLE:**
  - `feat_ready`=0 and `clf_inp` is frozen.
  - `scnt` counts from SETTLE_CYCLES-1 down to 0.
  - At `scnt==0`, `clf_out` is registered into `res_data`, `err_q` is copied into `res_err`, and the FSM moves to HOLD.
- **HOLD:**
  - `res_valid`=1. `res_data` and `res_err` are stable until the handshake.
  - On `res_valid & res_ready`: `sample_cnt`+1, `idx`←0, `err_q`←0, next state LOAD.
- `clf_inp` keeps the previous sample's slots until they are overwritten. No clearing occurs on entry to LOAD.
- `feat_valid` outside LOAD is ignored (not accepted, not an error).

## Timing
- **Reset values:**
  - `feat_ready`=1, `res_valid`=0, `res_data`=0, `res_err`=0, `sample_cnt`=0, `clf_inp`=0.
  - `idx`=0, `scnt`=SETTLE_CYCLES-1, state LOAD.
- **Latency:**
  - The last feature handshake is at edge T.
  - SETTLE spans edges T+1..T+SETTLE_CYCLES.
  - Capture happens at edge T+SETTLE_CYCLES.
  - `res_valid` is high from T+SETTLE_CYCLES.
- **Throughput:**
  - The result handshake at edge R returns the FSM to LOAD, so `feat_ready`=1 in the cycle after R.
  - Minimum sample period is NUM_A + SETTLE_CYCLES + 1 cycles.
- `res_ready` held high while entering HOLD: the handshake occurs on the first HOLD cycle.
- `rst_n` low mid-sample (any state): everything returns to reset values immediately. The partial sample is discarded and no result is produced.
- All outputs are registered. `clf_inp` changes only on LOAD handshakes.

## Structure
- Package `clf_stream_pkg` holds:
  - the state enum `clf_state_t` {LOAD, SETTLE, HOLD};
  - the localparams `IDX_W = $clog2(NUM_A)` and `SCNT_W = $clog2(SETTLE_CYCLES)+1`.
- One sub-module, `feature_slot_reg`. It is the `NUM_A`×`WIDTH_A` slot array with indexed write plus a zero-fill-above-index strobe, and it drives `clf_inp`.
- The FSM, settle counter and result register live in `clf_stream_wrapper`.

## Test plan
Defaults are 11/4/21 with SETTLE_CYCLES=3. `clf_out` is a bench model: the zero-extended sum of the slots.

1. **Normal sample.** Features 1..11, `feat_last` on the 11th, `res_ready`=1. Required: `res_data`=66, `res_err`=0, `res_valid` rises 3 cycles after the last beat, `sample_cnt`=1.
2. **Early last.** Stream 5,5,5 with `feat_last` on the 3rd, after a prior sample of all 15s. Required: slots 3..10 read 0, `res_data`=15, `res_err`=1.
3. **Missing last.** 11 beats of 2 with `feat_last`=0 throughout. Required: `res_data`=22, `res_err`=1, and the 12th beat is not accepted (`feat_ready`=0).
4. **Backpressure.** `res_ready`=0 for 10 cycles during HOLD. Required: `res_valid` stays 1, `res_data` is stable, `feat_ready`=0, `sample_cnt` is unchanged until the handshake.
5. **Reset mid-SETTLE.** Assert `rst_n`=0 asynchronously during a SETTLE cycle. Required: outputs take reset values immediately, and `res_valid` never pulses for that sample.
6. **Counter wrap and gapped input.** With CNT_W=2, run 5 samples with random `feat_valid` gaps. Required: `sample_cnt` sequence 1,2,3,0,1 and correct sums each time.
